alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the combinational 6502 ALU.
- Executes one operation per transaction on a WIDTH-bit datapath and produces the full flag set (N, V, Z, C, half-carry) for the status register.
- Binary ops complete in one cycle. Decimal-mode ADC/SBC runs digit-serially, one BCD nibble per cycle, through a small FSM.
- Sits between the operand latches and the P/accumulator write-back in the CPU core.

Parameters:
- WIDTH, 8, datapath width; must be a multiple of 4 and at least 4.
- NDIG, WIDTH/4, number of BCD digits; derived, not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- op  in  4  operation code (see Behaviour).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry in (for SBC: 1 = no borrow).
- bcd  in  1  decimal mode; affects ADC/SBC only.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  result word.
- c_out  out  1  carry / not-borrow.
- v_out  out  1  signed overflow.
- n_out  out  1  result MSB.
- z_out  out  1  result == 0.
- hc_out  out  1  carry out of digit 0.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; in_ready=1.
  - out_valid, result and all flags = 0; digit counter = 0.
  - An operation in flight is discarded with no output.
- Op codes:
  - 0 ADC: A+B+cin.
  - 1 SBC: A-B-(1-cin).
  - 2 AND, 3 ORA, 4 EOR.
  - 5 ASL: C=A[MSB], shift in 0.
  - 6 LSR: C=A[0], shift in 0.
  - 7 ROL: shift in cin, C=A[MSB].
  - 8 ROR: shift in cin, C=A[0].
  - 9 CMP: A-B with cin forced 1; C=(A>=B), V=0.
  - 10 INC: A+1, C=0, V=0.
  - 11 DEC: A-1, C=0, V=0.
  - 12 PASSB: result=B.
  - 13-15 illegal: result=A, C=cin, V=0, HC=0.
- Flags:
  - N=result[WIDTH-1] and Z=(result==0) for every op.
  - V is computed only for ADC/SBC, always from the binary sum, even in decimal mode; V=0 for all other ops.
  - HC = binary carry out of bit 3 for ADC/SBC, or the decimal digit-0 carry in decimal mode; 0 otherwise.
  - Logic ops: C=cin.
- Handshake:
  - Accept when in_valid && in_ready. a, b, op, cin and bcd are registered at acceptance; later input changes have no effect.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - out_valid = (state==DONE). result and flags are held stable while out_valid && !out_ready.
- FSM:
  - IDLE:
    - Accept of a binary op, or of any op with bcd=0, goes to DONE.
    - Accept of ADC/SBC with bcd=1 goes to CALC with digit counter k=0.
  - CALC:
    - Each cycle processes digit k, LSB digit first, carrying the decimal carry between digits.
    - At k==NDIG-1 go to DONE; otherwise k++.
  - DONE:
    - On out_ready with in_valid, accept a new op and branch as from IDLE (back-to-back, no bubble).
    - On out_ready without in_valid, go to IDLE.
    - Otherwise stay in DONE.
- Latency, accept edge T to first out_valid cycle:
  - binary: T+1.
  - decimal: T+NDIG+1, i.e. 3 cycles for WIDTH=8.
- Decimal digit cell, per nibble, deterministic for non-BCD inputs:
  - ADC: s = a_d + b_d + c (5 bits). If s>9 then s = s+6 and carry=1, else carry=0. Nibble = s[3:0].
  - SBC: d = a_d - b_d - (1-c) (signed). If d<0 then nibble = (d-6)[3:0] and c=0; else nibble = d[3:0] and c=1.
  - Final C = carry out of the last digit. N and Z come from the decimal result.

Decomposition:
- Shared package/include alu_defs:
  - op-code localparams (OP_ADC … OP_PASSB).
  - state encodings (S_IDLE=2'd0, S_CALC=2'd1, S_DONE=2'd2).
- Sub-module bcd_digit: a combinational one-nibble decimal add/sub cell with ports a_d, b_d, c_in, sub, nib, c_out. It is instantiated once and reused by the CALC loop.

Test Plan:
- Reset mid-CALC: accept ADC bcd=1, assert rst_n=0 the next cycle -> out_valid=0, result=0x00, all flags 0, in_ready=1, no late output.
- Binary ADC: WIDTH=8, a=0x50, b=0x50, cin=0 -> at T+1 result=0xA0, V=1, N=1, C=0, Z=0, HC=0.
- Decimal ADC:
  - a=0x58, b=0x46, cin=1 -> at T+3 result=0x05, C=1, HC=1.
  - a=0x99, b=0x01, cin=0 -> result=0x00, Z=1, C=1.
- Decimal SBC:
  - a=0x46, b=0x12, cin=1 -> result=0x34, C=1.
  - a=0x12, b=0x21, cin=1 -> result=0x91, C=0, N=1.
- Back-pressure and back-to-back:
  - Hold out_ready=0 for 4 cycles after ROR a=0x01, cin=1 -> result=0x80, C=1, N=1, held stable, in_ready=0.
  - Release with in_valid=1 and CMP a=0x10, b=0x10 -> next cycle result=0x00, Z=1, C=1.
- Parameter sweep, WIDTH=16, decimal ADC a=0x9999, b=0x0001, cin=0 -> at T+5 result=0x0000, C=1, Z=1; illegal op 14 -> result=a, C=cin.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: op-code and FSM state encodings.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADC   = 4'd0,
        OP_SBC   = 4'd1,
        OP_AND   = 4'd2,
        OP_ORA   = 4'd3,
        OP_EOR   = 4'd4,
        OP_ASL   = 4'd5,
        OP_LSR   = 4'd6,
        OP_ROL   = 4'd7,
        OP_ROR   = 4'd8,
        OP_CMP   = 4'd9,
        OP_INC   = 4'd10,
        OP_DEC   = 4'd11,
        OP_PASSB = 4'd12
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_bcd_digit.sv
// One-nibble decimal add/subtract cell; deterministic for non-BCD digits.
module bcd_digit (
    input  logic [3:0] a_d,
    input  logic [3:0] b_d,
    input  logic       c_in,
    input  logic       sub,
    output logic [3:0] nib,
    output logic       c_out
);

    logic [4:0] w_sum;
    logic [5:0] w_diff;

    always_comb begin
        w_sum  = {1'b0, a_d} + {1'b0, b_d} + {4'b0, c_in};
        w_diff = {2'b0, a_d} - {2'b0, b_d} - {5'b0, ~c_in};
        nib    = '0;
        c_out  = 1'b0;
        if (sub) begin
            if ($signed(w_diff) < 6'sd0) begin
                nib   = w_diff[3:0] - 4'd6;
                c_out = 1'b0;
            end else begin
                nib   = w_diff[3:0];
                c_out = 1'b1;
            end
        end else if (w_sum > 5'd9) begin
            nib   = w_sum[3:0] + 4'd6;
            c_out = 1'b1;
        end else begin
            nib   = w_sum[3:0];
            c_out = 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked 6502-style ALU: binary ops in one cycle, decimal ADC/SBC
// digit-serially through a reused bcd_digit cell.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             bcd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             v_out,
    output logic             n_out,
    output logic             z_out,
    output logic             hc_out,
    output logic             busy
);

    localparam int unsigned NDIG = WIDTH / 4;
    localparam int unsigned KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned MSB  = WIDTH - 1;

    state_t           r_state;
    logic [WIDTH-1:0] r_a, r_b, r_res;
    logic [KW-1:0]    r_k;
    logic             r_sub, r_carry, r_c, r_v, r_n, r_z, r_hc;

    logic             w_accept, w_dec;
    logic [WIDTH-1:0] w_bx, w_res, w_dres;
    logic [WIDTH:0]   w_sum;
    logic             w_c, w_v, w_hc;
    logic [3:0]       w_nib;
    logic             w_dc;

    assign in_ready = (r_state == S_IDLE) || (r_state == S_DONE && out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_dec    = bcd && (op == OP_ADC || op == OP_SBC);

    // SBC and CMP share the adder by inverting B; CMP forces the carry-in.
    always_comb begin
        w_bx  = (op == OP_SBC || op == OP_CMP) ? ~b : b;
        w_sum = {1'b0, a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, (op == OP_CMP) ? 1'b1 : cin};
        w_res = a;
        w_c   = cin;
        w_v   = 1'b0;
        w_hc  = 1'b0;
        case (op)
            OP_ADC, OP_SBC: begin
                w_res = w_sum[MSB:0];
                w_c   = w_sum[WIDTH];
                w_v   = (a[MSB] == w_bx[MSB]) && (w_sum[MSB] != a[MSB]);
                w_hc  = (5'(a[3:0]) + 5'(w_bx[3:0]) + 5'(cin)) > 5'd15;
            end
            OP_AND:   w_res = a & b;
            OP_ORA:   w_res = a | b;
            OP_EOR:   w_res = a ^ b;
            OP_ASL:   begin w_res = {a[MSB-1:0], 1'b0}; w_c = a[MSB]; end
            OP_LSR:   begin w_res = {1'b0, a[MSB:1]};   w_c = a[0];   end
            OP_ROL:   begin w_res = {a[MSB-1:0], cin};  w_c = a[MSB]; end
            OP_ROR:   begin w_res = {cin, a[MSB:1]};    w_c = a[0];   end
            OP_CMP:   begin w_res = w_sum[MSB:0]; w_c = w_sum[WIDTH]; end
            OP_INC:   begin w_res = a + WIDTH'(1); w_c = 1'b0; end
            OP_DEC:   begin w_res = a - WIDTH'(1); w_c = 1'b0; end
            OP_PASSB: w_res = b;
            default:  ;
        endcase
    end

    bcd_digit u_digit (
        .a_d   (r_a[{r_k, 2'b00} +: 4]),
        .b_d   (r_b[{r_k, 2'b00} +: 4]),
        .c_in  (r_carry),
        .sub   (r_sub),
        .nib   (w_nib),
        .c_out (w_dc)
    );

    always_comb begin
        w_dres = r_res;
        w_dres[{r_k, 2'b00} +: 4] = w_nib;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_k     <= '0;
            r_sub   <= 1'b0;
            r_carry <= 1'b0;
            r_c     <= 1'b0;
            r_v     <= 1'b0;
            r_n     <= 1'b0;
            r_z     <= 1'b0;
            r_hc    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_sub <= (op == OP_SBC);
                        r_v   <= w_v;
                        if (w_dec) begin
                            r_state <= S_CALC;
                            r_k     <= '0;
                            r_carry <= cin;
                            r_res   <= '0;
                        end else begin
                            r_state <= S_DONE;
                            r_res   <= w_res;
                            r_c     <= w_c;
                            r_hc    <= w_hc;
                            r_n     <= w_res[MSB];
                            r_z     <= (w_res == '0);
                        end
                    end else if (r_state == S_DONE && out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    r_res   <= w_dres;
                    r_carry <= w_dc;
                    if (r_k == '0) r_hc <= w_dc;
                    if (r_k == KW'(NDIG - 1)) begin
                        r_state <= S_DONE;
                        r_c     <= w_dc;
                        r_n     <= w_dres[MSB];
                        r_z     <= (w_dres == '0);
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign result    = r_res;
    assign c_out     = r_c;
    assign v_out     = r_v;
    assign n_out     = r_n;
    assign z_out     = r_z;
    assign hc_out    = r_hc;

endmodule
